mul_pipe: RTL and testbench
===========================

MUL_PIPE -- requirements
Module: mul_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width in bits (legal 8..64).
REQ-002 SHALL have parameter STAGES, default 5, number of register stages from operand capture to result (legal 2..8).
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1, operands and in_dst present this cycle.
REQ-006 SHALL have port in_a, input, WIDTH, signed multiplicand.
REQ-007 SHALL have port in_b, input, WIDTH, signed multiplier.
REQ-008 SHALL have port in_dst, input, 5, destination register index.
REQ-009 SHALL have port stall, input, 1, freezes the whole pipe.
REQ-010 SHALL have port flush, input, 1, kills all in-flight operations.
REQ-011 SHALL have port out_valid, output, 1, final stage holds a live result.
REQ-012 SHALL have port out_result, output, WIDTH, low WIDTH bits of a*b.
REQ-013 SHALL have port out_zero, output, 1, out_result equals 0.
REQ-014 SHALL have port out_overflow, output, 1, signed product does not fit in WIDTH bits.
REQ-015 SHALL have port out_dst, output, 5, destination of the final-stage result.
REQ-016 SHALL have port dst_busy, output, 32, bit r set while any valid stage holds dst r.

Function
REQ-017 SHALL hold STAGES entries, each {valid, result, zero, overflow, dst}; stage 1 captures inputs, stage STAGES drives the outputs.
REQ-018 SHALL compute in stage 1: full 2*WIDTH signed product; result = low WIDTH bits; zero = (result == 0); overflow = 1 when upper WIDTH bits differ from WIDTH copies of result bit WIDTH-1.
REQ-019 SHALL, with stall=0 and flush=0, on each edge load stage 1 from inputs (valid=in_valid) and shift stage k into stage k+1 for all k.
REQ-020 SHALL give latency of exactly STAGES edges: an operation sampled at edge n appears on the outputs after edge n+STAGES-1 and is held until the next advancing edge.
REQ-021 SHALL accept one operation per cycle; in_valid=0 inserts a bubble (valid=0) into stage 1.
REQ-022 SHALL, with stall=1 and flush=0, keep all stages unchanged and ignore the inputs; stalled operations are not lost or duplicated.
REQ-023 SHALL, with flush=1, clear every stage valid on that edge, regardless of stall and in_valid; operands presented in the flush cycle are discarded.
REQ-024 SHALL drive out_result, out_zero, out_overflow, out_dst to 0 whenever out_valid=0.
REQ-025 SHALL compute dst_busy combinationally from current stage contents; bit 0 is always 0; stale dst values in invalid stages do not set bits.
REQ-026 SHALL produce out_zero=1, out_overflow=0 for a*0 and 0*b.
REQ-027 SHALL report overflow for min*(-1) (e.g. WIDTH=32: 0x80000000*0xFFFFFFFF -> result 0x80000000, overflow=1).

Reset
REQ-028 SHALL, on an edge with rst_n=0, clear all stage valid bits and payload fields to 0, taking priority over flush, stall and inputs.
REQ-029 SHALL drive out_valid=0, all other outputs 0, dst_busy=0 in the cycle after reset is applied, including reset asserted mid-operation.
REQ-030 SHALL resume accepting operations on the first edge with rst_n=1.

Verification (WIDTH=32, STAGES=5)
REQ-031 SHALL verify: a=3, b=7, dst=9 at edge 0, no stall -> out_valid=1, result 21, zero=0, overflow=0, dst 9 after edge 4; dst_busy[9]=1 from edge 0 through edge 4.
REQ-032 SHALL verify: back-to-back ops (2*2, -3*5, 0x10000*0x10000) -> results 4, 0xFFFFFFF1, 0x00000000 with zero=1 and overflow=1, on three consecutive cycles.
REQ-033 SHALL verify: op at edge 0, stall high for edges 2-4 -> result appears after edge 7, held for exactly one cycle, with no duplicates.
REQ-034 SHALL verify: three ops in flight, flush together with stall and in_valid -> out_valid=0 and dst_busy=0 next cycle; no flushed result ever appears.
REQ-035 SHALL verify: rst_n=0 for one edge with the pipe full -> all outputs 0 next cycle; a new op after reset completes with normal latency.
REQ-036 SHALL verify: 0x80000000*0xFFFFFFFF with dst=0 -> result 0x80000000, overflow=1, out_dst=0; dst_busy stays 0 throughout.

Source files
------------

// File: rtl/mul_pipe.sv
// mul_pipe: stallable, flushable pipelined signed multiplier with per-stage
// destination tracking for a register scoreboard.
//
// Ports:
//   clk          - clock, all state updates on rising edge
//   rst_n        - synchronous active-low reset
//   in_valid     - operands and in_dst present this cycle
//   in_a, in_b   - signed operands, WIDTH bits
//   in_dst       - destination register index (5 bits)
//   stall        - freeze every stage, ignore inputs
//   flush        - kill every in-flight operation
//   out_valid    - final stage holds a live result
//   out_result   - low WIDTH bits of a*b
//   out_zero     - out_result == 0
//   out_overflow - signed product does not fit in WIDTH bits
//   out_dst      - destination of the final-stage result
//   dst_busy     - bit r set while any valid stage holds dst r (bit 0 never set)
module mul_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    input  logic [4:0]        in_dst,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_result,
    output logic              out_zero,
    output logic              out_overflow,
    output logic [4:0]        out_dst,
    output logic [31:0]       dst_busy
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned DW = 5;

    // Stage-1 arithmetic on the raw inputs
    logic signed [PW-1:0]  prod_c;
    logic [WIDTH-1:0]      res_c;
    logic                  ovf_c;

    assign prod_c = PW'($signed(in_a)) * PW'($signed(in_b));
    assign res_c  = prod_c[WIDTH-1:0];
    // Product fits only if the upper half is a pure sign extension of the result
    assign ovf_c  = (prod_c[PW-1:WIDTH] != {WIDTH{prod_c[WIDTH-1]}});

    // Pipeline state; index 0 is stage 1, index STAGES-1 drives the outputs
    logic [STAGES-1:0] st_valid;
    logic [WIDTH-1:0]  st_result [STAGES];
    logic [STAGES-1:0] st_zero;
    logic [STAGES-1:0] st_ovf;
    logic [DW-1:0]     st_dst    [STAGES];

    // Stage registers. Payload is zeroed whenever an entry is not valid, so the
    // final stage can drive the outputs directly and still read 0 when idle.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                st_valid[k]  <= 1'b0;
                st_result[k] <= '0;
                st_zero[k]   <= 1'b0;
                st_ovf[k]    <= 1'b0;
                st_dst[k]    <= '0;
            end
        end else if (!stall) begin
            st_valid[0]  <= in_valid;
            st_result[0] <= in_valid ? res_c : '0;
            st_zero[0]   <= in_valid && (res_c == '0);
            st_ovf[0]    <= in_valid && ovf_c;
            st_dst[0]    <= in_valid ? in_dst : '0;
            for (int unsigned k = 1; k < STAGES; k++) begin
                st_valid[k]  <= st_valid[k-1];
                st_result[k] <= st_result[k-1];
                st_zero[k]   <= st_zero[k-1];
                st_ovf[k]    <= st_ovf[k-1];
                st_dst[k]    <= st_dst[k-1];
            end
        end
    end

    assign out_valid    = st_valid[STAGES-1];
    assign out_result   = st_result[STAGES-1];
    assign out_zero     = st_zero[STAGES-1];
    assign out_overflow = st_ovf[STAGES-1];
    assign out_dst      = st_dst[STAGES-1];

    // Scoreboard view of pending destinations; r0 is never a real hazard
    always_comb begin
        dst_busy = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            if (st_valid[k]) begin
                dst_busy[st_dst[k]] = 1'b1;
            end
        end
        dst_busy[0] = 1'b0;
    end

endmodule

// File: tb/tb_mul_pipe.sv
// tb_mul_pipe: directed self-checking bench for mul_pipe (WIDTH=32, STAGES=5).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mul_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_dst;
    logic        stall;
    logic        flush;
    logic        out_valid;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_overflow;
    logic [4:0]  out_dst;
    logic [31:0] dst_busy;

    int checks = 0;
    int errors = 0;

    mul_pipe #(.WIDTH(32), .STAGES(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_dst       (in_dst),
        .stall        (stall),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_result   (out_result),
        .out_zero     (out_zero),
        .out_overflow (out_overflow),
        .out_dst      (out_dst),
        .dst_busy     (dst_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] d);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_dst   = d;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Checks the full output bundle
    task automatic chk_out(input string tag, input logic v, input logic [31:0] r,
                           input logic z, input logic o, input logic [4:0] d);
        chk({tag, ".valid"}, 64'(out_valid), 64'(v));
        chk({tag, ".result"}, 64'(out_result), 64'(r));
        chk({tag, ".zero"}, 64'(out_zero), 64'(z));
        chk({tag, ".ovf"}, 64'(out_overflow), 64'(o));
        chk({tag, ".dst"}, 64'(out_dst), 64'(d));
    endtask

    task automatic idle_out(input string tag);
        chk_out(tag, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        op(1'b0, 32'h0, 32'h0, 5'd0);
        tick();
        tick();
        idle_out("reset");
        chk("reset.busy", 64'(dst_busy), 64'h0);
        rst_n = 1'b1;

        // 3*7 -> 21, dst 9, latency 5 edges
        op(1'b1, 32'd3, 32'd7, 5'd9);
        tick();                                   // edge 0
        op(1'b0, 32'h0, 32'h0, 5'd0);
        chk("basic.busy_e0", 64'(dst_busy), 64'h200);
        for (int e = 1; e <= 3; e++) begin
            tick();
            chk("basic.busy_mid", 64'(dst_busy), 64'h200);
            chk("basic.valid_mid", 64'(out_valid), 64'h0);
        end
        tick();                                   // edge 4
        chk_out("basic.e4", 1'b1, 32'd21, 1'b0, 1'b0, 5'd9);
        chk("basic.busy_e4", 64'(dst_busy), 64'h200);
        tick();
        idle_out("basic.e5");
        chk("basic.busy_e5", 64'(dst_busy), 64'h0);

        // Back-to-back: 2*2, -3*5, 0x10000*0x10000
        op(1'b1, 32'd2, 32'd2, 5'd1);
        tick();                                   // edge 0
        op(1'b1, 32'hFFFF_FFFD, 32'd5, 5'd2);
        tick();                                   // edge 1
        op(1'b1, 32'h0001_0000, 32'h0001_0000, 5'd3);
        tick();                                   // edge 2
        op(1'b0, 32'h0, 32'h0, 5'd0);
        chk("b2b.busy", 64'(dst_busy), 64'h0000_000E);
        tick();                                   // edge 3
        tick();                                   // edge 4
        chk_out("b2b.op1", 1'b1, 32'd4, 1'b0, 1'b0, 5'd1);
        tick();
        chk_out("b2b.op2", 1'b1, 32'hFFFF_FFF1, 1'b0, 1'b0, 5'd2);
        tick();
        chk_out("b2b.op3", 1'b1, 32'h0, 1'b1, 1'b1, 5'd3);
        tick();
        idle_out("b2b.after");

        // Stall edges 2-4: 5*6 appears after edge 7, once; stalled inputs ignored
        op(1'b1, 32'd5, 32'd6, 5'd4);
        tick();                                   // edge 0
        op(1'b0, 32'h0, 32'h0, 5'd0);
        tick();                                   // edge 1
        stall = 1'b1;
        op(1'b1, 32'd11, 32'd13, 5'd7);
        for (int e = 2; e <= 4; e++) begin
            tick();
            chk("stall.valid", 64'(out_valid), 64'h0);
            chk("stall.busy", 64'(dst_busy), 64'h10);
        end
        stall = 1'b0;
        op(1'b0, 32'h0, 32'h0, 5'd0);
        tick();                                   // edge 5
        chk("stall.e5", 64'(out_valid), 64'h0);
        tick();                                   // edge 6
        chk("stall.e6", 64'(out_valid), 64'h0);
        tick();                                   // edge 7
        chk_out("stall.e7", 1'b1, 32'd30, 1'b0, 1'b0, 5'd4);
        for (int e = 8; e <= 11; e++) begin
            tick();
            idle_out("stall.after");
        end

        // Flush with stall and in_valid: everything dies
        op(1'b1, 32'd1, 32'd1, 5'd10);
        tick();
        op(1'b1, 32'd2, 32'd1, 5'd11);
        tick();
        op(1'b1, 32'd3, 32'd1, 5'd12);
        tick();
        chk("flush.busy_pre", 64'(dst_busy), 64'h0000_1C00);
        op(1'b1, 32'd4, 32'd1, 5'd13);
        flush = 1'b1;
        stall = 1'b1;
        tick();
        flush = 1'b0;
        stall = 1'b0;
        op(1'b0, 32'h0, 32'h0, 5'd0);
        idle_out("flush.next");
        chk("flush.busy", 64'(dst_busy), 64'h0);
        for (int e = 0; e < 6; e++) begin
            tick();
            chk("flush.never", 64'(out_valid), 64'h0);
        end

        // Reset with full pipe, then a fresh op with normal latency
        for (int i = 1; i <= 5; i++) begin
            op(1'b1, 32'(i), 32'd100, 5'(i));
            tick();
        end
        chk_out("rst.full", 1'b1, 32'd100, 1'b0, 1'b0, 5'd1);
        chk("rst.busy_full", 64'(dst_busy), 64'h0000_003E);
        rst_n = 1'b0;
        flush = 1'b1;
        op(1'b1, 32'd7, 32'd7, 5'd8);
        tick();
        rst_n = 1'b1;
        flush = 1'b0;
        idle_out("rst.next");
        chk("rst.busy", 64'(dst_busy), 64'h0);
        op(1'b1, 32'd9, 32'd9, 5'd6);
        tick();                                   // edge 0
        op(1'b0, 32'h0, 32'h0, 5'd0);
        chk("rst.new_busy", 64'(dst_busy), 64'h40);
        for (int e = 1; e <= 3; e++) begin
            tick();
            chk("rst.new_wait", 64'(out_valid), 64'h0);
        end
        tick();                                   // edge 4
        chk_out("rst.new", 1'b1, 32'd81, 1'b0, 1'b0, 5'd6);
        tick();

        // min * -1 overflows, dst 0 never marks busy
        op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
        tick();                                   // edge 0
        op(1'b0, 32'h0, 32'h0, 5'd0);
        for (int e = 1; e <= 4; e++) begin
            chk("min.busy", 64'(dst_busy), 64'h0);
            tick();
        end
        chk_out("min.e4", 1'b1, 32'h8000_0000, 1'b0, 1'b1, 5'd0);
        chk("min.busy_e4", 64'(dst_busy), 64'h0);

        // a*0 and 0*b give zero without overflow
        op(1'b1, 32'h1234_5678, 32'h0, 5'd20);
        tick();
        op(1'b1, 32'h0, 32'h8000_0000, 5'd21);
        tick();
        op(1'b0, 32'h0, 32'h0, 5'd0);
        tick();
        tick();
        tick();
        chk_out("zero.a0", 1'b1, 32'h0, 1'b1, 1'b0, 5'd20);
        tick();
        chk_out("zero.0b", 1'b1, 32'h0, 1'b1, 1'b0, 5'd21);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
